// File: rtl/traffic_pkg.sv
// Shared types, default timing constants and helpers for the traffic-light green-time logic.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package traffic_pkg;

    localparam int DELAY_W = 32;   // width of the light FSM green-delay inputs
    localparam int PROD_W  = 48;   // width of the registered count*step product

    localparam int CLK_FREQ_DEF      = 50_000_000;
    localparam int BASE_GREEN_MS_DEF = 100;
    localparam int STEP_MS_DEF       = 10;
    localparam int MIN_GREEN_MS_DEF  = 50;
    localparam int MAX_GREEN_MS_DEF  = 400;
    localparam int COUNT_W_DEF       = 8;

    // First pipeline stage of the delay computation for one direction.
    typedef struct packed {
        logic              vld;
        logic [PROD_W-1:0] prod;
    } s1_t;

    // Milliseconds to clock cycles, done in 64 bits so large clocks do not overflow.
    function automatic logic [63:0] ms_to_cyc(input logic [63:0] ms, input logic [63:0] clk_freq);
        return (ms * clk_freq) / 64'd1000;
    endfunction

    // Saturate to the delay width, then clamp into [min_cyc, max_cyc].
    function automatic logic [DELAY_W-1:0] clamp_delay(input logic [63:0] sum,
                                                       input logic [63:0] min_cyc,
                                                       input logic [63:0] max_cyc);
        logic [63:0] s;
        s = (sum > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : sum;
        if (s < min_cyc) s = min_cyc;
        if (s > max_cyc) s = max_cyc;
        if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
        return DELAY_W'(s);
    endfunction

endpackage

// File: rtl/arrival_counter.sv
// Counts rising edges of one presence sensor into a saturating counter with clear.
// Latency: count reflects an arrival 1 clock after the sensor rises (+2 with SENSOR_SYNC_EN).
// Backpressure: none; every qualifying edge is counted until saturation.
// Ports: clk, rst (sync, active-low), sensor (raw detector), clr (restart counting), count.
// Build option: SENSOR_SYNC_EN adds a 2-flop synchronizer in front of the edge detect.
module arrival_counter
    import traffic_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sensor,
    input  logic               clr,
    output logic [COUNT_W-1:0] count
);

    logic               sensor_s;
    logic               sensor_q, sensor_d;
    logic               arrival;
    logic [COUNT_W-1:0] count_q, count_d;

`ifdef SENSOR_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = sensor;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sensor_s = sync2_q;
`else
    assign sensor_s = sensor;
`endif

    always_comb begin
        sensor_d = sensor_s;
        arrival  = sensor_s & ~sensor_q;
        count_d  = count_q;
        if (clr) begin
            // A clear that coincides with an arrival keeps that arrival.
            count_d = COUNT_W'(arrival);
        end else if (arrival && (count_q != '1)) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sensor_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sensor_q <= sensor_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/green_time_calc.sv
// Adaptive NS/EW green-time generator feeding the intersection light FSM delay inputs.
// Latency: delay output and upd pulse appear 2 clocks after the green falling edge is detected.
// Backpressure: none; commits are unconditional, delays hold between commits.
// Ports: clk, rst (sync, active-low), ns/ew_sensor, ns/ew_green_in (from FSM),
//        NS/EW_GREEN_DELAY (cycles), ns/ew_delay_upd (1-cycle pulse), conflict (sticky).
// Build option: SENSOR_SYNC_EN synchronizes the sensors (2 extra cycles of arrival latency).
module green_time_calc
    import traffic_pkg::*;
#(
    parameter int CLK_FREQ      = CLK_FREQ_DEF,
    parameter int BASE_GREEN_MS = BASE_GREEN_MS_DEF,
    parameter int STEP_MS       = STEP_MS_DEF,
    parameter int MIN_GREEN_MS  = MIN_GREEN_MS_DEF,
    parameter int MAX_GREEN_MS  = MAX_GREEN_MS_DEF,
    parameter int COUNT_W       = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ns_sensor,
    input  logic               ew_sensor,
    input  logic               ns_green_in,
    input  logic               ew_green_in,
    output logic [DELAY_W-1:0] NS_GREEN_DELAY,
    output logic [DELAY_W-1:0] EW_GREEN_DELAY,
    output logic               ns_delay_upd,
    output logic               ew_delay_upd,
    output logic               conflict
);

    localparam logic [63:0] BASE_CYC = ms_to_cyc(64'(BASE_GREEN_MS), 64'(CLK_FREQ));
    localparam logic [63:0] STEP_CYC = ms_to_cyc(64'(STEP_MS), 64'(CLK_FREQ));
    localparam logic [63:0] MIN_CYC  = ms_to_cyc(64'(MIN_GREEN_MS), 64'(CLK_FREQ));
    localparam logic [63:0] MAX_CYC  = ms_to_cyc(64'(MAX_GREEN_MS), 64'(CLK_FREQ));
    localparam logic [DELAY_W-1:0] RST_DELAY = clamp_delay(BASE_CYC, MIN_CYC, MAX_CYC);

    if (MIN_GREEN_MS > MAX_GREEN_MS) begin : g_clamp_check
        $error("green_time_calc: MIN_GREEN_MS (%0d) exceeds MAX_GREEN_MS (%0d)",
               MIN_GREEN_MS, MAX_GREEN_MS);
    end

    logic               ns_green_q, ns_green_d;
    logic               ew_green_q, ew_green_d;
    logic               ns_fall, ew_fall;
    logic [COUNT_W-1:0] ns_count, ew_count;
    s1_t                ns_s1_q, ns_s1_d;
    s1_t                ew_s1_q, ew_s1_d;
    logic [DELAY_W-1:0] ns_delay_q, ns_delay_d;
    logic [DELAY_W-1:0] ew_delay_q, ew_delay_d;
    logic               ns_upd_q, ns_upd_d;
    logic               ew_upd_q, ew_upd_d;
    logic               conflict_q, conflict_d;

    // A direction starts waiting when its own green ends.
    arrival_counter #(.COUNT_W(COUNT_W)) u_ns_cnt (
        .clk    (clk),
        .rst    (rst),
        .sensor (ns_sensor),
        .clr    (ns_fall),
        .count  (ns_count)
    );

    arrival_counter #(.COUNT_W(COUNT_W)) u_ew_cnt (
        .clk    (clk),
        .rst    (rst),
        .sensor (ew_sensor),
        .clr    (ew_fall),
        .count  (ew_count)
    );

    always_comb begin
        ns_green_d = ns_green_in;
        ew_green_d = ew_green_in;
        ns_fall    = ~ns_green_in & ns_green_q;
        ew_fall    = ~ew_green_in & ew_green_q;
        conflict_d = conflict_q | (ns_green_in & ew_green_in);

        // The end of the opposing green commits this direction's count, so the new
        // delay settles during the opposing yellow. The count read here is the
        // pre-increment value; a same-cycle arrival lands in the counter only.
        ns_s1_d.vld  = ew_fall;
        ns_s1_d.prod = PROD_W'(64'(ns_count) * STEP_CYC);
        ew_s1_d.vld  = ns_fall;
        ew_s1_d.prod = PROD_W'(64'(ew_count) * STEP_CYC);

        ns_upd_d   = ns_s1_q.vld;
        ns_delay_d = ns_delay_q;
        if (ns_s1_q.vld) begin
            ns_delay_d = clamp_delay(BASE_CYC + 64'(ns_s1_q.prod), MIN_CYC, MAX_CYC);
        end

        ew_upd_d   = ew_s1_q.vld;
        ew_delay_d = ew_delay_q;
        if (ew_s1_q.vld) begin
            ew_delay_d = clamp_delay(BASE_CYC + 64'(ew_s1_q.prod), MIN_CYC, MAX_CYC);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ns_green_q <= 1'b0;
            ew_green_q <= 1'b0;
            ns_s1_q    <= '0;
            ew_s1_q    <= '0;
            ns_delay_q <= RST_DELAY;
            ew_delay_q <= RST_DELAY;
            ns_upd_q   <= 1'b0;
            ew_upd_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            ns_green_q <= ns_green_d;
            ew_green_q <= ew_green_d;
            ns_s1_q    <= ns_s1_d;
            ew_s1_q    <= ew_s1_d;
            ns_delay_q <= ns_delay_d;
            ew_delay_q <= ew_delay_d;
            ns_upd_q   <= ns_upd_d;
            ew_upd_q   <= ew_upd_d;
            conflict_q <= conflict_d;
        end
    end

    assign NS_GREEN_DELAY = ns_delay_q;
    assign EW_GREEN_DELAY = ew_delay_q;
    assign ns_delay_upd   = ns_upd_q;
    assign ew_delay_upd   = ew_upd_q;
    assign conflict       = conflict_q;

endmodule

// File: tb/tb_green_time_calc.sv
// Bench for green_time_calc: three parameterisations driven by one stimulus stream,
// a cycle model pushes expected commits into a scoreboard, a negedge monitor pops them.
module tb_green_time_calc;

    localparam int N = 3;
`ifdef SENSOR_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ns_sensor, ew_sensor, ns_green, ew_green;
    logic [31:0] ns_dly [N];
    logic [31:0] ew_dly [N];
    logic        ns_upd [N];
    logic        ew_upd [N];
    logic        conf   [N];

    // A: defaults, B: 4-bit counter, C: base 20 ms (below the minimum clamp)
    green_time_calc #(.CLK_FREQ(1000), .BASE_GREEN_MS(100), .STEP_MS(10),
                      .MIN_GREEN_MS(50), .MAX_GREEN_MS(400), .COUNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .ns_sensor(ns_sensor), .ew_sensor(ew_sensor),
        .ns_green_in(ns_green), .ew_green_in(ew_green),
        .NS_GREEN_DELAY(ns_dly[0]), .EW_GREEN_DELAY(ew_dly[0]),
        .ns_delay_upd(ns_upd[0]), .ew_delay_upd(ew_upd[0]), .conflict(conf[0]));

    green_time_calc #(.CLK_FREQ(1000), .BASE_GREEN_MS(100), .STEP_MS(10),
                      .MIN_GREEN_MS(50), .MAX_GREEN_MS(400), .COUNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .ns_sensor(ns_sensor), .ew_sensor(ew_sensor),
        .ns_green_in(ns_green), .ew_green_in(ew_green),
        .NS_GREEN_DELAY(ns_dly[1]), .EW_GREEN_DELAY(ew_dly[1]),
        .ns_delay_upd(ns_upd[1]), .ew_delay_upd(ew_upd[1]), .conflict(conf[1]));

    green_time_calc #(.CLK_FREQ(1000), .BASE_GREEN_MS(20), .STEP_MS(10),
                      .MIN_GREEN_MS(50), .MAX_GREEN_MS(400), .COUNT_W(8)) u_dut_c (
        .clk(clk), .rst(rst), .ns_sensor(ns_sensor), .ew_sensor(ew_sensor),
        .ns_green_in(ns_green), .ew_green_in(ew_green),
        .NS_GREEN_DELAY(ns_dly[2]), .EW_GREEN_DELAY(ew_dly[2]),
        .ns_delay_upd(ns_upd[2]), .ew_delay_upd(ew_upd[2]), .conflict(conf[2]));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int base_ms [N] = '{100, 100, 20};
    int cnt_max [N] = '{255, 15, 255};

    function automatic int exp_delay(input int k, input int cnt);
        int s;
        s = base_ms[k] + cnt * 10;
        if (s < 50)  s = 50;
        if (s > 400) s = 400;
        return s;
    endfunction

    typedef struct {
        int cyc;
        int k;
        int dir;   // 0 = NS, 1 = EW
        int val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   m_cnt [N][2];
    int   m_dly [N][2];
    bit   m_conf = 1'b0;
    bit   m_sync1 [2];
    bit   m_sync2 [2];
    bit   m_sprev [2];
    bit   m_gprev [2];

    always @(posedge clk) begin : model
        bit sens [2];
        bit grn  [2];
        bit seff [2];
        bit arr  [2];
        bit fall [2];
        cyc++;
        sens[0] = ns_sensor; sens[1] = ew_sensor;
        grn[0]  = ns_green;  grn[1]  = ew_green;
        if (!rst) begin
            sb.delete();
            m_conf = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_sync1[d] = 0; m_sync2[d] = 0; m_sprev[d] = 0; m_gprev[d] = 0;
                for (int k = 0; k < N; k++) begin
                    m_cnt[k][d] = 0;
                    m_dly[k][d] = exp_delay(k, 0);
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                seff[d]    = (SYNC_LAT != 0) ? m_sync2[d] : sens[d];
                arr[d]     = seff[d] & ~m_sprev[d];
                m_sync2[d] = m_sync1[d];
                m_sync1[d] = sens[d];
                m_sprev[d] = seff[d];
                fall[d]    = ~grn[d] & m_gprev[d];
                m_gprev[d] = grn[d];
            end
            for (int k = 0; k < N; k++) begin
                if (fall[1]) sb.push_back('{cyc + 1, k, 0, exp_delay(k, m_cnt[k][0])});
                if (fall[0]) sb.push_back('{cyc + 1, k, 1, exp_delay(k, m_cnt[k][1])});
                for (int d = 0; d < 2; d++) begin
                    if (fall[d])
                        m_cnt[k][d] = arr[d] ? 1 : 0;
                    else if (arr[d] && m_cnt[k][d] < cnt_max[k])
                        m_cnt[k][d]++;
                end
            end
            m_conf = m_conf | (grn[0] & grn[1]);
        end
    end

    always @(negedge clk) begin : monitor
        bit   eu [N][2];
        exp_t e;
        if (cyc > 0) begin
            for (int k = 0; k < N; k++) begin eu[k][0] = 0; eu[k][1] = 0; end
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                eu[e.k][e.dir] = 1;
                m_dly[e.k][e.dir] = e.val;
            end
            for (int k = 0; k < N; k++) begin
                chk($sformatf("c%0d.upd_ns%0d", cyc, k), 64'(ns_upd[k]), 64'(eu[k][0]));
                chk($sformatf("c%0d.upd_ew%0d", cyc, k), 64'(ew_upd[k]), 64'(eu[k][1]));
                chk($sformatf("c%0d.dly_ns%0d", cyc, k), 64'(ns_dly[k]), 64'(m_dly[k][0]));
                chk($sformatf("c%0d.dly_ew%0d", cyc, k), 64'(ew_dly[k]), 64'(m_dly[k][1]));
                chk($sformatf("c%0d.conf%0d",   cyc, k), 64'(conf[k]),   64'(m_conf));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic pulse(input bit ns, input int n);
        repeat (n) begin
            if (ns) ns_sensor = 1'b1; else ew_sensor = 1'b1;
            step(1);
            if (ns) ns_sensor = 1'b0; else ew_sensor = 1'b0;
            step(1);
        end
    endtask

    // Call right after driving a green low: checks no pulse on the detect edge,
    // then the pulse and value one clock later, then pulse gone.
    task automatic expect_commit(input bit do_ns, input bit do_ew,
                                 input int na, input int nb, input int nc,
                                 input int ea, input int eb, input int ec);
        int nv [N];
        int ev [N];
        nv[0] = na; nv[1] = nb; nv[2] = nc;
        ev[0] = ea; ev[1] = eb; ev[2] = ec;
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (do_ns) chk($sformatf("early_upd_ns%0d", k), 64'(ns_upd[k]), 64'd0);
            if (do_ew) chk($sformatf("early_upd_ew%0d", k), 64'(ew_upd[k]), 64'd0);
        end
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (do_ns) begin
                chk($sformatf("commit_upd_ns%0d", k), 64'(ns_upd[k]), 64'd1);
                chk($sformatf("commit_dly_ns%0d", k), 64'(ns_dly[k]), 64'(nv[k]));
            end
            if (do_ew) begin
                chk($sformatf("commit_upd_ew%0d", k), 64'(ew_upd[k]), 64'd1);
                chk($sformatf("commit_dly_ew%0d", k), 64'(ew_dly[k]), 64'(ev[k]));
            end
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (do_ns) chk($sformatf("late_upd_ns%0d", k), 64'(ns_upd[k]), 64'd0);
            if (do_ew) chk($sformatf("late_upd_ew%0d", k), 64'(ew_upd[k]), 64'd0);
        end
        @(posedge clk); #2;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_ns%0d", tag, k), 64'(ns_dly[k]), (k == 2) ? 64'd50 : 64'd100);
            chk($sformatf("%s_ew%0d", tag, k), 64'(ew_dly[k]), (k == 2) ? 64'd50 : 64'd100);
            chk($sformatf("%s_upd%0d", tag, k), 64'({ns_upd[k], ew_upd[k]}), 64'd0);
            chk($sformatf("%s_conf%0d", tag, k), 64'(conf[k]), 64'd0);
        end
        @(posedge clk); #2;
    endtask

    initial begin
        rst = 1'b0; ns_sensor = 1'b0; ew_sensor = 1'b0; ns_green = 1'b0; ew_green = 1'b0;
        step(3);
        rst = 1'b1;
        check_reset_state("rst");

        // 0 EW arrivals committed; C clamps 20 up to 50
        ns_green = 1'b1; step(3); ns_green = 1'b0;
        expect_commit(0, 1, 0, 0, 0, 100, 100, 50);

        // 5 NS arrivals while EW green
        ew_green = 1'b1; pulse(1, 5); step(SYNC_LAT + 2); ew_green = 1'b0;
        expect_commit(1, 0, 150, 150, 70, 0, 0, 0);

        // 20 NS arrivals: B saturates at 15
        ns_green = 1'b1; step(2); ns_green = 1'b0;
        expect_commit(0, 1, 0, 0, 0, 100, 100, 50);
        ew_green = 1'b1; pulse(1, 20); step(SYNC_LAT + 2); ew_green = 1'b0;
        expect_commit(1, 0, 300, 250, 220, 0, 0, 0);

        // Arrivals coincident with ns_fall: EW commit sees 3, NS counter restarts at 1
        ns_green = 1'b1; pulse(0, 3); step(SYNC_LAT + 1);
        ns_sensor = 1'b1; ew_sensor = 1'b1; step(SYNC_LAT); ns_green = 1'b0;
        expect_commit(0, 1, 0, 0, 0, 130, 130, 50);
        ns_sensor = 1'b0; ew_sensor = 1'b0;
        ew_green = 1'b1; step(SYNC_LAT + 2); ew_green = 1'b0;
        expect_commit(1, 0, 110, 110, 50, 0, 0, 0);

        // 40 NS arrivals: upper clamp on A and C
        ns_green = 1'b1; step(2); ns_green = 1'b0;
        expect_commit(0, 1, 0, 0, 0, 100, 100, 50);
        ew_green = 1'b1; pulse(1, 40); step(SYNC_LAT + 2); ew_green = 1'b0;
        expect_commit(1, 0, 400, 250, 400, 0, 0, 0);

        // Both greens high (conflict), then both fall together: two commits at once
        pulse(0, 2); step(SYNC_LAT + 1);
        ns_green = 1'b1; ew_green = 1'b1; step(1);
        ns_green = 1'b0; ew_green = 1'b0;
        expect_commit(1, 1, 400, 250, 400, 120, 120, 50);
        step(5);
        @(negedge clk);
        for (int k = 0; k < N; k++) chk($sformatf("conf_sticky%0d", k), 64'(conf[k]), 64'd1);
        @(posedge clk); #2;

        // Reset the cycle after a commit edge: pulse discarded, everything back to reset values
        ew_green = 1'b1; step(2); ew_green = 1'b0; step(1);
        rst = 1'b0; step(1); rst = 1'b1;
        check_reset_state("midrst");

        // Arrival latency: one cycle after the sensor rises, the count is 1 only without sync
        ew_green = 1'b1; ns_sensor = 1'b1; step(1); ew_green = 1'b0;
        expect_commit(1, 0, (SYNC_LAT == 0) ? 110 : 100, (SYNC_LAT == 0) ? 110 : 100, 50, 0, 0, 0);
        ns_sensor = 1'b0;

        step(5);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
